// File: rtl/l2_forward_lookup.sv
// l2_forward_lookup: learns source MACs, looks up the destination MAC, patches egress/drop into metadata word0
module l2_forward_lookup #(
  parameter int          NUM_ENTRIES = 16,
  parameter logic [31:0] AGE_PERIOD  = 32'd100000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         metadata_in_valid,
  input  logic [133:0] metadata_in,
  input  logic         ready_in,
  output logic         ready_out,
  output logic         metadata_out_valid,
  output logic [133:0] metadata_out,
  output logic [15:0]  learn_count
);
  localparam int IW = $clog2(NUM_ENTRIES);
  typedef enum logic [1:0] {IDLE, META1, META2, PKT} state_t;
  state_t state, state_nxt;
  logic slot_valid;
  logic [133:0] slot, out_word;
  logic [NUM_ENTRIES-1:0] tbl_valid, tbl_hit;
  logic [47:0] tbl_mac [NUM_ENTRIES];
  logic [7:0] tbl_port [NUM_ENTRIES];
  logic [IW-1:0] rr_ptr, s_idx, free_idx, learn_idx;
  logic [31:0] age_cnt;
  logic [1:0] tag;
  logic [47:0] dmac, smac;
  logic [7:0] ingress, d_port, egress;
  logic d_hit, s_hit, free_found, drop, is_w1, learn, learn_new, emit, sweep;
  assign tag = metadata_in[133:132];
  assign dmac = metadata_in[127:80];
  assign smac = metadata_in[79:32];
  assign ingress = slot[127:120];
  assign is_w1 = metadata_in_valid && state == META1 && tag == 2'b11;
  assign learn = is_w1 && !smac[40];
  assign learn_new = learn && !s_hit;
  assign learn_idx = s_hit ? s_idx : free_found ? free_idx : rr_ptr;
  assign emit = metadata_in_valid || (slot_valid && slot[133:132] == 2'b10);
  assign sweep = age_cnt == AGE_PERIOD - 32'd1;
  assign egress = (dmac[40] || !d_hit) ? 8'hFF : d_port;
  assign drop = !dmac[40] && d_hit && d_port == ingress;
  assign out_word = is_w1 ? {slot[133:120], egress, drop, slot[110:0]} : slot;
  // search the table for dmac, smac and the lowest free entry
  always_comb begin
    d_hit = 1'b0;
    d_port = 8'hFF;
    s_hit = 1'b0;
    s_idx = '0;
    free_found = 1'b0;
    free_idx = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (tbl_valid[i] && tbl_mac[i] == dmac) begin
        d_hit = 1'b1;
        d_port = tbl_port[i];
      end
      if (tbl_valid[i] && tbl_mac[i] == smac) begin
        s_hit = 1'b1;
        s_idx = IW'(i);
      end
      if (!tbl_valid[i] && !free_found) begin
        free_found = 1'b1;
        free_idx = IW'(i);
      end
    end
  end
  // classifier next state, advancing only on valid words
  always_comb begin
    state_nxt = state;
    if (metadata_in_valid)
      case (state)
        IDLE:    state_nxt = tag == 2'b01 ? META1 : IDLE;
        META1:   state_nxt = tag == 2'b11 ? META2 : tag == 2'b10 ? IDLE : PKT;
        META2:   state_nxt = PKT;
        default: state_nxt = tag == 2'b10 ? IDLE : PKT;
      endcase
  end
  // classifier state register
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nxt;
  // MAC table: aging sweep first, so a same-cycle learn leaves its entry valid with hit set
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      tbl_valid <= '0;
      tbl_hit <= '0;
      rr_ptr <= '0;
      age_cnt <= '0;
      learn_count <= '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        tbl_mac[i] <= '0;
        tbl_port[i] <= '0;
      end
    end else begin
      age_cnt <= sweep ? '0 : age_cnt + 32'd1;
      if (sweep) begin
        tbl_valid <= tbl_valid & tbl_hit;
        tbl_hit <= '0;
      end
      if (learn) begin
        tbl_valid[learn_idx] <= 1'b1;
        tbl_hit[learn_idx] <= 1'b1;
        tbl_mac[learn_idx] <= smac;
        tbl_port[learn_idx] <= ingress;
      end
      if (learn_new && learn_count != 16'hFFFF) learn_count <= learn_count + 16'd1;
      if (learn_new && !free_found) rr_ptr <= rr_ptr + 1'b1;
    end
  // one-word delay slot; a held tail drains on its own
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      slot_valid <= 1'b0;
      slot <= '0;
      metadata_out_valid <= 1'b0;
      metadata_out <= '0;
      ready_out <= 1'b1;
    end else begin
      ready_out <= ready_in;
      metadata_out_valid <= emit && slot_valid;
      if (emit && slot_valid) metadata_out <= out_word;
      if (emit) begin
        slot_valid <= metadata_in_valid;
        slot <= metadata_in;
      end
    end
endmodule
